// File: rtl/sd_timeout_watchdog.sv
// sd_timeout_watchdog
// Avalon-MM slave watchdog driven by the interval timer's timeout tick.
// Once armed it counts ticks, and software must kick it before the count
// reaches the programmed limit. If it does not, the block flags an expiry
// and can raise an interrupt. It protects SD-card transactions from a hung
// card.
//
// Register map (16-bit):
//   0 STATUS  : {14'b0, armed, expired}; any write clears expired
//   1 CONTROL : bit0 irq_enable, bit1 auto_rearm (stored)
//               bit2 start, bit3 stop (strobes, read back as 0)
//   2 LIMIT   : tick limit, 0 = never expire (count saturates)
//   3 KICK    : any write zeroes the count; reads 0
//   4 COUNT   : current tick count (read-only)
//   5-7       : read 0, writes ignored

module sd_timeout_watchdog #(
    parameter logic [15:0] RESET_LIMIT = 16'd10,
    parameter bit          TICK_EDGE   = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    input  logic        tick_in,
    output logic        irq
);

    localparam logic [2:0] ADDR_STATUS  = 3'd0;
    localparam logic [2:0] ADDR_CONTROL = 3'd1;
    localparam logic [2:0] ADDR_LIMIT   = 3'd2;
    localparam logic [2:0] ADDR_KICK    = 3'd3;
    localparam logic [2:0] ADDR_COUNT   = 3'd4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        EXPIRED = 2'd2
    } state_e;

    state_e      state;
    logic [15:0] count;
    logic [15:0] limit;
    logic        irq_enable;
    logic        auto_rearm;
    logic        expired;
    logic        tick;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic bus_write;
    logic wr_status;
    logic wr_control;
    logic wr_limit;
    logic wr_kick;
    logic start_cmd;
    logic stop_cmd;

    assign bus_write  = chipselect & ~write_n;
    assign wr_status  = bus_write & (address == ADDR_STATUS);
    assign wr_control = bus_write & (address == ADDR_CONTROL);
    assign wr_limit   = bus_write & (address == ADDR_LIMIT);
    assign wr_kick    = bus_write & (address == ADDR_KICK);
    assign start_cmd  = wr_control & writedata[2];
    assign stop_cmd   = wr_control & writedata[3];

    // ------------------------------------------------------------------
    // Tick detection
    // ------------------------------------------------------------------
    generate
        if (TICK_EDGE) begin : g_edge_tick
            logic tick_d;

            // Delay tick_in by one cycle to find its rising edges.
            // The register clears on reset, so a level that is already
            // high when reset releases is still visible as one edge.
            // NOTE: the flop is written with a non-blocking assignment, so
            // every clocked block samples the value from before the edge,
            // whatever order the simulator runs the blocks in.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    tick_d <= 1'b0;
                end else begin
                    tick_d <= tick_in;
                end
            end

            assign tick = tick_in & ~tick_d;
        end else begin : g_level_tick
            assign tick = tick_in;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Count arithmetic
    // ------------------------------------------------------------------
    logic [16:0] count_plus;
    logic        limit_hit;
    logic [15:0] count_step;
    logic        cmd_pending;
    logic        expire_evt;

    // The 17-bit sum keeps the compare exact when count is 16'hFFFF.
    assign count_plus = {1'b0, count} + 17'd1;
    assign limit_hit  = (limit != 16'd0) && (count_plus == {1'b0, limit});

    // With a zero limit the count saturates instead of wrapping.
    assign count_step = ((limit == 16'd0) && (count == 16'hFFFF))
                        ? count : count_plus[15:0];

    // Any higher-priority bus action in this cycle masks the tick.
    assign cmd_pending = stop_cmd | start_cmd | wr_kick | wr_limit;
    assign expire_evt  = (state == ARMED) & tick & limit_hit & ~cmd_pending;

    // ------------------------------------------------------------------
    // Watchdog state machine and its registers
    // ------------------------------------------------------------------
    // Apply the bus commands in priority order
    // (stop > start > kick > LIMIT write > tick), then update the sticky
    // expiry flag.
    // NOTE: every register here, including limit and the control bits,
    // is reset asynchronously. After reset the block is in a known state
    // without needing any clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            count      <= 16'd0;
            limit      <= RESET_LIMIT;
            irq_enable <= 1'b0;
            auto_rearm <= 1'b0;
            expired    <= 1'b0;
        end else begin
            if (wr_control) begin
                irq_enable <= writedata[0];
                auto_rearm <= writedata[1];
            end

            if (wr_limit) begin
                limit <= writedata;
            end

            if (stop_cmd) begin
                state <= IDLE;
            end else if (start_cmd) begin
                state <= ARMED;
                count <= 16'd0;
            end else if (wr_kick) begin
                if (state != EXPIRED) begin
                    count <= 16'd0;
                end
            end else if (wr_limit) begin
                // Restart the window so the new limit counts from zero.
                if (state == ARMED) begin
                    count <= 16'd0;
                end
            end else if (tick && (state == ARMED)) begin
                if (limit_hit) begin
                    if (auto_rearm) begin
                        count <= 16'd0;
                    end else begin
                        count <= limit;
                        state <= EXPIRED;
                    end
                end else begin
                    count <= count_step;
                end
            end

            // A new expiry wins over a coincident STATUS write.
            if (expire_evt) begin
                expired <= 1'b1;
            end else if (wr_status) begin
                expired <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [15:0] rd_mux;

    // Select the register addressed this cycle. Unmapped addresses
    // return zero.
    // NOTE: rd_mux is given a default before the case statement, so every
    // path assigns it and no latch is inferred.
    always_comb begin
        rd_mux = 16'd0;
        case (address)
            ADDR_STATUS:  rd_mux = {14'd0, (state == ARMED), expired};
            ADDR_CONTROL: rd_mux = {14'd0, auto_rearm, irq_enable};
            ADDR_LIMIT:   rd_mux = limit;
            ADDR_COUNT:   rd_mux = count;
            default:      rd_mux = 16'd0;
        endcase
    end

    // Register read data every cycle, with one cycle of latency and no
    // dependence on chipselect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= 16'd0;
        end else begin
            readdata <= rd_mux;
        end
    end

    // The interrupt follows the stored flags directly.
    assign irq = expired & irq_enable;

endmodule

// File: tb/tb_sd_timeout_watchdog.sv
// tb_sd_timeout_watchdog
// Self-checking bench for sd_timeout_watchdog. Two instances share the
// register bus:
//   u_dut_e : edge-triggered tick, checked cycle by cycle against a
//             behavioural model
//   u_dut_l : level-sensitive tick, used for the 16-bit saturation run

module tb_sd_timeout_watchdog;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        write_n;
    logic [15:0] writedata;
    logic        cs_e;
    logic        cs_l;
    logic        tick_e;
    logic        tick_l;
    logic [15:0] rd_e;
    logic [15:0] rd_l;
    logic        irq_e;
    logic        irq_l;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    sd_timeout_watchdog #(.RESET_LIMIT(16'd10), .TICK_EDGE(1'b1)) u_dut_e (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (cs_e),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (rd_e),
        .tick_in    (tick_e),
        .irq        (irq_e)
    );

    sd_timeout_watchdog #(.RESET_LIMIT(16'd10), .TICK_EDGE(1'b0)) u_dut_l (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (cs_l),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (rd_l),
        .tick_in    (tick_l),
        .irq        (irq_l)
    );

    // ------------------------------------------------------------------
    // Behavioural model of the edge-tick watchdog.
    // It works on plain integers and two flags:
    //   running = window open
    //   frozen  = expired and waiting for software
    // ------------------------------------------------------------------
    bit          m_running;
    bit          m_frozen;
    bit          m_expired;
    bit          m_irqen;
    bit          m_rearm;
    bit          m_prev;
    int          m_count;
    int          m_limit;
    logic [15:0] exp_rd;
    logic        exp_irq;

    task automatic model_reset();
        m_running = 0;
        m_frozen  = 0;
        m_expired = 0;
        m_irqen   = 0;
        m_rearm   = 0;
        m_prev    = 0;
        m_count   = 0;
        m_limit   = 10;
        exp_rd    = 16'd0;
        exp_irq   = 1'b0;
    endtask

    function automatic logic [15:0] model_read(input logic [2:0] a);
        logic [15:0] v;
        v = 16'd0;
        if (a == 3'd0) v = {14'd0, m_running, m_expired};
        if (a == 3'd1) v = {14'd0, m_rearm, m_irqen};
        if (a == 3'd2) v = m_limit[15:0];
        if (a == 3'd4) v = m_count[15:0];
        return v;
    endfunction

    task automatic model_cycle(input bit cs, input bit wr, input logic [2:0] a,
                               input logic [15:0] d, input bit t);
        bit is_wr;
        bit tick;
        bit new_exp;
        exp_rd  = model_read(a);
        is_wr   = cs && wr;
        tick    = t && !m_prev;
        m_prev  = t;
        new_exp = 0;
        if (is_wr && a == 3'd1 && d[3]) begin
            m_running = 0;
            m_frozen  = 0;
        end else if (is_wr && a == 3'd1 && d[2]) begin
            m_running = 1;
            m_frozen  = 0;
            m_count   = 0;
        end else if (is_wr && a == 3'd3) begin
            if (!m_frozen) m_count = 0;
        end else if (is_wr && a == 3'd2) begin
            if (m_running) m_count = 0;
        end else if (tick && m_running) begin
            if (m_limit != 0 && m_count + 1 == m_limit) begin
                new_exp = 1;
                if (m_rearm) begin
                    m_count = 0;
                end else begin
                    m_count   = m_limit;
                    m_running = 0;
                    m_frozen  = 1;
                end
            end else if (m_limit == 0) begin
                m_count = (m_count < 65535) ? m_count + 1 : 65535;
            end else begin
                m_count = (m_count + 1) % 65536;
            end
        end
        if (is_wr && a == 3'd2) m_limit = int'(d);
        if (is_wr && a == 3'd1) begin
            m_irqen = d[0];
            m_rearm = d[1];
        end
        if (new_exp) m_expired = 1;
        else if (is_wr && a == 3'd0) m_expired = 0;
        exp_irq = m_expired && m_irqen;
    endtask

    // Drive one bus cycle on the edge DUT. Inputs change 1 time unit after
    // the rising edge, and outputs are looked at 1 time unit after the
    // next rising edge.
    task automatic cyc(input bit cs, input bit wr, input logic [2:0] a,
                       input logic [15:0] d, input bit t);
        cs_e      = cs;
        cs_l      = 1'b0;
        write_n   = ~wr;
        address   = a;
        writedata = d;
        tick_e    = t;
        tick_l    = 1'b0;
        model_cycle(cs, wr, a, d, t);
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [15:0] d, input bit t);
        cyc(1'b1, 1'b1, a, d, t);
    endtask

    task automatic rd_reg(input logic [2:0] a, input bit t);
        cyc(1'b1, 1'b0, a, 16'd0, t);
    endtask

    // Drive one bus cycle on the level DUT. The edge DUT sees an idle bus.
    task automatic lcyc(input bit wr, input logic [2:0] a, input logic [15:0] d);
        cs_e      = 1'b0;
        cs_l      = 1'b1;
        write_n   = ~wr;
        address   = a;
        writedata = d;
        tick_e    = 1'b0;
        tick_l    = 1'b0;
        model_cycle(1'b0, wr, a, d, 1'b0);
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        reset_n   = 1'b0;
        cs_e      = 1'b0;
        cs_l      = 1'b0;
        write_n   = 1'b1;
        address   = 3'd0;
        writedata = 16'd0;
        tick_e    = 1'b1;
        tick_l    = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        tests_run++;
        if (rd_e !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_readdata: got %h want %h", rd_e, 16'd0);
        end
        tests_run++;
        if (irq_e !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_irq: got %b want 0", irq_e);
        end
        reset_n = 1'b1;
        rd_reg(3'd2, 1'b1);
        tests_run++;
        if (rd_e !== 16'd10) begin
            tests_failed++;
            $display("FAIL reset_limit: got %0d want 10", rd_e);
        end
        rd_reg(3'd4, 1'b1);
        rd_reg(3'd4, 1'b0);
        tests_run++;
        if (rd_e !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_no_count: got %0d want 0", rd_e);
        end
    endtask

    task automatic test_expire();
        wr_reg(3'd2, 16'd3, 1'b0);
        wr_reg(3'd1, 16'h0005, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            cyc(1'b1, 1'b0, 3'd0, 16'd0, 1'b1);
            tests_run++;
            if (irq_e !== (i == 3)) begin
                tests_failed++;
                $display("FAIL expire_irq_tick%0d: got %b want %b", i, irq_e, (i == 3));
            end
            cyc(1'b1, 1'b0, 3'd4, 16'd0, 1'b0);
        end
        rd_reg(3'd0, 1'b0);
        tests_run++;
        if (rd_e !== 16'h0001) begin
            tests_failed++;
            $display("FAIL expire_status: got %h want 0001", rd_e);
        end
        rd_reg(3'd4, 1'b0);
        tests_run++;
        if (rd_e !== 16'd3) begin
            tests_failed++;
            $display("FAIL expire_count: got %0d want 3", rd_e);
        end
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 1'b0, 3'd4, 16'd0, 1'b1);
            cyc(1'b1, 1'b0, 3'd4, 16'd0, 1'b0);
        end
        rd_reg(3'd4, 1'b0);
        tests_run++;
        if (rd_e !== 16'd3 || irq_e !== 1'b1) begin
            tests_failed++;
            $display("FAIL expire_frozen: got count %0d irq %b want 3 1", rd_e, irq_e);
        end
    endtask

    task automatic test_kick();
        wr_reg(3'd1, 16'h0008, 1'b0);
        wr_reg(3'd0, 16'h0000, 1'b0);
        wr_reg(3'd2, 16'd3, 1'b0);
        wr_reg(3'd1, 16'h0005, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            cyc(1'b1, 1'b0, 3'd4, 16'd0, 1'b1);
            cyc(1'b1, 1'b0, 3'd4, 16'd0, 1'b0);
            tests_run++;
            if (rd_e > 16'd2 || irq_e !== 1'b0 || rd_e !== exp_rd) begin
                tests_failed++;
                $display("FAIL kick_bound_tick%0d: got count %0d irq %b want %0d (<=2) 0",
                         i, rd_e, irq_e, exp_rd);
            end
            if (i % 2 == 0) wr_reg(3'd3, 16'hBEEF, 1'b0);
        end
        cyc(1'b1, 1'b0, 3'd4, 16'd0, 1'b1);
        cyc(1'b1, 1'b0, 3'd4, 16'd0, 1'b0);
        cyc(1'b1, 1'b0, 3'd4, 16'd0, 1'b1);
        cyc(1'b1, 1'b0, 3'd4, 16'd0, 1'b0);
        wr_reg(3'd3, 16'h0000, 1'b1);
        rd_reg(3'd4, 1'b0);
        tests_run++;
        if (rd_e !== 16'd0 || irq_e !== 1'b0) begin
            tests_failed++;
            $display("FAIL kick_with_tick: got count %0d irq %b want 0 0", rd_e, irq_e);
        end
        rd_reg(3'd0, 1'b0);
        tests_run++;
        if (rd_e !== 16'h0002) begin
            tests_failed++;
            $display("FAIL kick_status: got %h want 0002", rd_e);
        end
    endtask

    task automatic test_auto_rearm();
        wr_reg(3'd1, 16'h0008, 1'b0);
        wr_reg(3'd0, 16'h0000, 1'b0);
        wr_reg(3'd1, 16'h0007, 1'b0);
        wr_reg(3'd2, 16'd2, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            cyc(1'b1, 1'b0, 3'd4, 16'd0, 1'b1);
            if (i <= 2) begin
                tests_run++;
                if (irq_e !== (i == 2)) begin
                    tests_failed++;
                    $display("FAIL rearm_irq_tick%0d: got %b want %b", i, irq_e, (i == 2));
                end
            end
            cyc(1'b1, 1'b0, (i == 2) ? 3'd0 : 3'd4, 16'd0, 1'b0);
            if (i == 2) begin
                tests_run++;
                if (rd_e !== 16'h0003) begin
                    tests_failed++;
                    $display("FAIL rearm_status: got %h want 0003", rd_e);
                end
            end
        end
        tests_run++;
        if (rd_e !== 16'd1) begin
            tests_failed++;
            $display("FAIL rearm_count: got %0d want 1", rd_e);
        end
        wr_reg(3'd0, 16'h1234, 1'b0);
        tests_run++;
        if (irq_e !== 1'b0) begin
            tests_failed++;
            $display("FAIL rearm_irq_clear: got %b want 0", irq_e);
        end
        rd_reg(3'd0, 1'b0);
        tests_run++;
        if (rd_e !== 16'h0002) begin
            tests_failed++;
            $display("FAIL rearm_still_armed: got %h want 0002", rd_e);
        end
    endtask

    task automatic test_stop();
        wr_reg(3'd1, 16'h000C, 1'b0);
        rd_reg(3'd0, 1'b0);
        tests_run++;
        if (rd_e !== 16'h0000) begin
            tests_failed++;
            $display("FAIL stop_status: got %h want 0000", rd_e);
        end
        rd_reg(3'd1, 1'b0);
        tests_run++;
        if (rd_e !== 16'h0000) begin
            tests_failed++;
            $display("FAIL stop_control: got %h want 0000", rd_e);
        end
    endtask

    task automatic test_random();
        bit          cs;
        bit          wr;
        bit          t;
        logic [2:0]  a;
        logic [15:0] d;
        for (int i = 0; i < 3000; i++) begin
            wr = ($urandom_range(0, 3) == 0);
            a  = 3'($urandom_range(0, 7));
            cs = wr ? ($urandom_range(0, 7) != 0) : 1'($urandom_range(0, 1));
            if (a == 3'd1)      d = 16'($urandom_range(0, 15));
            else if (a == 3'd2) d = 16'($urandom_range(0, 6));
            else                d = 16'($urandom);
            t = 1'($urandom_range(0, 1));
            cyc(cs, wr, a, d, t);
            tests_run++;
            if (rd_e !== exp_rd || irq_e !== exp_irq) begin
                tests_failed++;
                $display("FAIL random_cycle%0d: got rd %h irq %b want rd %h irq %b",
                         i, rd_e, irq_e, exp_rd, exp_irq);
            end
        end
    endtask

    task automatic test_async_reset();
        wr_reg(3'd1, 16'h0008, 1'b0);
        wr_reg(3'd2, 16'd1, 1'b0);
        wr_reg(3'd1, 16'h0005, 1'b0);
        cyc(1'b1, 1'b0, 3'd0, 16'd0, 1'b1);
        cyc(1'b1, 1'b0, 3'd0, 16'd0, 1'b0);
        wr_reg(3'd2, 16'd5, 1'b0);
        wr_reg(3'd1, 16'h0005, 1'b0);
        cyc(1'b1, 1'b0, 3'd4, 16'd0, 1'b1);
        cyc(1'b1, 1'b0, 3'd4, 16'd0, 1'b0);
        cyc(1'b1, 1'b0, 3'd4, 16'd0, 1'b1);
        cyc(1'b1, 1'b0, 3'd4, 16'd0, 1'b0);
        tests_run++;
        if (rd_e !== 16'd2 || irq_e !== 1'b1) begin
            tests_failed++;
            $display("FAIL areset_precondition: got count %0d irq %b want 2 1", rd_e, irq_e);
        end
        #3;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (rd_e !== 16'd0 || irq_e !== 1'b0) begin
            tests_failed++;
            $display("FAIL areset_immediate: got rd %h irq %b want 0000 0", rd_e, irq_e);
        end
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        rd_reg(3'd4, 1'b0);
        tests_run++;
        if (rd_e !== 16'd0 || irq_e !== 1'b0) begin
            tests_failed++;
            $display("FAIL areset_count: got count %0d irq %b want 0 0", rd_e, irq_e);
        end
        rd_reg(3'd2, 1'b0);
        tests_run++;
        if (rd_e !== 16'd10) begin
            tests_failed++;
            $display("FAIL areset_limit: got %0d want 10", rd_e);
        end
    endtask

    task automatic test_saturate();
        lcyc(1'b1, 3'd2, 16'd0);
        lcyc(1'b1, 3'd1, 16'h0005);
        cs_l    = 1'b0;
        address = 3'd4;
        tick_l  = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        tick_l = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if (rd_l !== 16'hFFFE) begin
            tests_failed++;
            $display("FAIL sat_before: got %h want fffe", rd_l);
        end
        tick_l = 1'b1;
        @(posedge clk);
        #1;
        tick_l = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if (rd_l !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL sat_reach: got %h want ffff", rd_l);
        end
        tick_l = 1'b1;
        repeat (4465) @(posedge clk);
        #1;
        tick_l = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if (rd_l !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL sat_hold: got %h want ffff", rd_l);
        end
        address = 3'd0;
        @(posedge clk);
        #1;
        tests_run++;
        if (rd_l !== 16'h0002 || irq_l !== 1'b0) begin
            tests_failed++;
            $display("FAIL sat_no_expiry: got status %h irq %b want 0002 0", rd_l, irq_l);
        end
    endtask

    // Global time bound so the run always ends.
    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_expire();
        test_kick();
        test_auto_rearm();
        test_stop();
        test_random();
        test_async_reset();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
